// File: rtl/ad7606_pkg.sv
// Shared types, sizes and sample-word helpers for the AD7606 device emulator.
package ad7606_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    READ = 2'd2
  } ad7606_state_e;

  localparam int NCH   = 8;
  localparam int SEQ_W = 12;
  localparam int CNT_W = 32;

  function automatic logic [15:0] sample_word(input logic [2:0] k, input logic rng,
                                              input logic [SEQ_W-1:0] seq);
    return {k, rng, seq};
  endfunction

  // Oversampling exponent 7 is reserved on the real part and behaves as 0.
  function automatic logic [2:0] os_eff(input logic [2:0] os);
    return (os == 3'd7) ? 3'd0 : os;
  endfunction
endpackage

// File: rtl/ad7606_if.sv
// Pin bundle between an AD7606 controller (master) and the device emulator (slave).
interface ad7606_if;
  import ad7606_pkg::*;

  // Strobe-level pins, no valid/ready: a conversion starts on the cycle cvtA&cvtB
  // first reads high, and a word is served on each rd high-to-low edge taken with cs low.
  logic          cvtA;
  logic          cvtB;
  logic          cs;
  logic          rd;
  logic          range;
  logic          phy_rst;
  logic [2:0]    os;
  logic          busy;
  logic          fdata;
  logic [15:0]   data_out;
  logic          data_oe;
  logic          overrun;
  logic          short_read;
  ad7606_state_e dbg_state;

  modport master (
    output cvtA, cvtB, cs, rd, range, phy_rst, os,
    input  busy, fdata, data_out, data_oe, overrun, short_read, dbg_state
  );

  modport slave (
    input  cvtA, cvtB, cs, rd, range, phy_rst, os,
    output busy, fdata, data_out, data_oe, overrun, short_read, dbg_state
  );
endinterface

// File: rtl/ad7606_edge.sv
// Registered single-edge detector; FALL selects falling instead of rising edges.
module ad7606_edge #(
  parameter bit FALL    = 1'b0,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic d_q;
  logic d_d;

  always_comb d_d = d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d_d;
  end

  assign pulse = FALL ? (~d & d_q) : (d & ~d_q);
endmodule

// File: rtl/ad7606_emu.sv
// AD7606 device emulator: timed conversions, eight deterministic channel words per conversion.
module ad7606_emu
  import ad7606_pkg::*;
#(
  parameter int CONV_CYCLES = 200
) (
  input logic     clk,
  input logic     rst,
  ad7606_if.slave bus
);
  localparam logic [3:0] NREAD_MAX = 4'(NCH);

  ad7606_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             range_lat_q, range_lat_d;
  logic [2:0]       ch_ptr_q, ch_ptr_d;
  logic [3:0]       nread_q, nread_d;
  logic             busy_q, busy_d;
  logic             fdata_q, fdata_d;
  logic [15:0]      data_q, data_d;
  logic             oe_q, oe_d;
  logic             overrun_q, overrun_d;
  logic             short_read_q, short_read_d;

  logic             start_raw, start_rise, start, rd_fall, rd_hit;
  logic [CNT_W-1:0] conv_len;

  assign start_raw = bus.cvtA & bus.cvtB;

  ad7606_edge #(.FALL(1'b0), .RST_VAL(1'b0)) u_start_edge (
    .clk(clk), .rst(rst), .d(start_raw), .pulse(start_rise)
  );

  ad7606_edge #(.FALL(1'b1), .RST_VAL(1'b1)) u_rd_edge (
    .clk(clk), .rst(rst), .d(bus.rd), .pulse(rd_fall)
  );

  assign start    = start_rise & ~bus.phy_rst;
  assign rd_hit   = rd_fall & ~bus.cs;
  assign conv_len = (CNT_W'(CONV_CYCLES) << os_eff(bus.os)) - CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      seq_q        <= '0;
      range_lat_q  <= 1'b0;
      ch_ptr_q     <= '0;
      nread_q      <= '0;
      busy_q       <= 1'b0;
      fdata_q      <= 1'b0;
      data_q       <= '0;
      oe_q         <= 1'b0;
      overrun_q    <= 1'b0;
      short_read_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      seq_q        <= seq_d;
      range_lat_q  <= range_lat_d;
      ch_ptr_q     <= ch_ptr_d;
      nread_q      <= nread_d;
      busy_q       <= busy_d;
      fdata_q      <= fdata_d;
      data_q       <= data_d;
      oe_q         <= oe_d;
      overrun_q    <= overrun_d;
      short_read_q <= short_read_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.phy_rst) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = CONV;
        CONV:    if (cnt_q == '0) state_d = READ;
        READ:    if (start) state_d = CONV;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    seq_d        = seq_q;
    range_lat_d  = range_lat_q;
    ch_ptr_d     = ch_ptr_q;
    nread_d      = nread_q;
    busy_d       = busy_q;
    fdata_d      = fdata_q;
    data_d       = data_q;
    overrun_d    = overrun_q;
    short_read_d = short_read_q;
    oe_d         = ~bus.cs;
    if (bus.phy_rst) begin
      cnt_d        = '0;
      seq_d        = '0;
      ch_ptr_d     = '0;
      nread_d      = '0;
      busy_d       = 1'b0;
      fdata_d      = 1'b0;
      data_d       = '0;
      overrun_d    = 1'b0;
      short_read_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d  = conv_len;
            busy_d = 1'b1;
          end
        end
        CONV: begin
          // A start on the final count cycle is flagged but not queued.
          if (start) overrun_d = 1'b1;
          if (cnt_q == '0) begin
            busy_d      = 1'b0;
            seq_d       = seq_q + SEQ_W'(1);
            range_lat_d = bus.range;
            ch_ptr_d    = '0;
            nread_d     = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        READ: begin
          if (start) begin
            cnt_d  = conv_len;
            busy_d = 1'b1;
            if (nread_q < NREAD_MAX) short_read_d = 1'b1;
          end else if (rd_hit) begin
            data_d   = sample_word(ch_ptr_q, range_lat_q, seq_q);
            fdata_d  = (ch_ptr_q == 3'd0);
            ch_ptr_d = ch_ptr_q + 3'd1;
            if (nread_q < NREAD_MAX) nread_d = nread_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.fdata      = fdata_q;
  assign bus.data_out   = data_q;
  assign bus.data_oe    = oe_q;
  assign bus.overrun    = overrun_q;
  assign bus.short_read = short_read_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_ad7606_emu.sv
// Bench for ad7606_emu: random conversions and reads against a pin-level behavioural model.
module tb_ad7606_emu;
  import ad7606_pkg::*;

  localparam int CONV_CYCLES = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ad7606_if bus ();

  ad7606_emu #(.CONV_CYCLES(CONV_CYCLES)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboards: {fdata, data_out} after each rd strobe, and busy pulse widths.
  logic [16:0] exp_q[$];
  int          exp_busy_q[$];

  // Behavioural device model: 0 idle, 1 converting, 2 serving reads.
  int          m_st, m_seq, m_ptr, m_nread, m_rlat, m_len, t_done;
  logic [16:0] m_out;
  bit          m_ovr, m_short;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_st = 0; m_seq = 0; m_ptr = 0; m_nread = 0; m_rlat = 0;
    m_out = '0; m_ovr = 0; m_short = 0;
  endtask

  task automatic model_start();
    int eo;
    if (m_st == 1) begin
      m_ovr = 1;
    end else begin
      if (m_st == 2 && m_nread < 8) m_short = 1;
      eo    = (bus.os == 3'd7) ? 0 : int'(bus.os);
      m_len = CONV_CYCLES * (1 << eo);
      exp_busy_q.push_back(m_len);
      m_st  = 1;
    end
  endtask

  task automatic do_start(input bit with_read);
    bit was_conv;
    if (with_read) begin
      step(); bus.cs = 1'b0;
    end
    step();
    bus.cvtA = 1'b1; bus.cvtB = 1'b1;
    if (with_read) bus.rd = 1'b0;
    was_conv = (m_st == 1);
    model_start();
    // Start wins over a simultaneous read: bus contents must stay as they were.
    if (with_read) exp_q.push_back(m_out);
    step();
    bus.cvtA = 1'b0; bus.cvtB = 1'b0;
    if (!was_conv) t_done = cyc + m_len;
    if (with_read) begin
      step(); bus.rd = 1'b1;
      step(); bus.cs = 1'b1;
    end
  endtask

  task automatic wait_conv();
    while (cyc < t_done + 1) step();
    m_seq   = (m_seq + 1) % 4096;
    m_rlat  = int'(bus.range);
    m_ptr   = 0;
    m_nread = 0;
    m_st    = 2;
    bus.range = 1'($urandom_range(0, 1));
  endtask

  task automatic do_read(input bit cs_v);
    step(); bus.cs = cs_v;
    step(); bus.rd = 1'b0;
    if (!cs_v && m_st == 2) begin
      m_out   = 17'(((m_ptr == 0) ? 65536 : 0) + m_ptr * 8192 + m_rlat * 4096 + m_seq);
      m_ptr   = (m_ptr + 1) % 8;
      if (m_nread < 8) m_nread++;
    end
    exp_q.push_back(m_out);
    @(negedge clk);
    check("data_oe", 32'(bus.data_oe), 32'(!cs_v));
    step(); step(); bus.rd = 1'b1;
    step(); bus.cs = 1'b1;
  endtask

  task automatic check_flags();
    @(negedge clk);
    check("overrun", 32'(bus.overrun), 32'(m_ovr));
    check("short_read", 32'(bus.short_read), 32'(m_short));
  endtask

  task automatic do_phy();
    step(); bus.phy_rst = 1'b1;
    model_reset();
    step(); bus.phy_rst = 1'b0;
    @(negedge clk);
    check("phy_busy", 32'(bus.busy), 32'd0);
    check("phy_state", 32'(bus.dbg_state), 32'(IDLE));
    check("phy_data", 32'(bus.data_out), 32'd0);
    check("phy_fdata", 32'(bus.fdata), 32'd0);
    check("phy_overrun", 32'(bus.overrun), 32'd0);
    check("phy_short", 32'(bus.short_read), 32'd0);
  endtask

  // Read monitor: every rd high-to-low seen on the pins retires one expected word.
  initial begin
    logic        rd_prev;
    logic        r;
    logic [16:0] e;
    rd_prev = 1'b1;
    forever begin
      @(posedge clk);
      r = bus.rd;
      if (rd_prev && !r) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL read_unexpected: got %0h expected no strobe", {bus.fdata, bus.data_out});
        end else begin
          e = exp_q.pop_front();
          check("read_word", 32'({bus.fdata, bus.data_out}), 32'(e));
        end
      end
      rd_prev = r;
    end
  end

  // Busy monitor: width of each busy pulse in clock cycles.
  initial begin
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) begin
        w++;
      end else if (w != 0) begin
        if (exp_busy_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL busy_unexpected: got width %0d expected no pulse", w);
        end else begin
          check("busy_width", 32'(w), 32'(exp_busy_q.pop_front()));
        end
        w = 0;
      end
    end
  end

  initial begin
    int n;
    bus.cvtA = 1'b0; bus.cvtB = 1'b0; bus.cs = 1'b1; bus.rd = 1'b1;
    bus.range = 1'b0; bus.phy_rst = 1'b0; bus.os = 3'd0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_fdata", 32'(bus.fdata), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    check("rst_oe", 32'(bus.data_oe), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    check("rst_short", 32'(bus.short_read), 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));

    // First conversion, os 0, range 0: words 0001, 2001 ... E001.
    bus.os = 3'd0; bus.range = 1'b0;
    do_start(0); wait_conv(); check_flags();
    repeat (8) do_read(1'b0);
    check_flags();

    // Soft reset, then os 2 with range 1 and an extra start mid-conversion.
    do_phy();
    bus.os = 3'd2; bus.range = 1'b1;
    do_start(0);
    repeat (100) step();
    do_start(0);
    wait_conv(); check_flags();
    repeat (8) do_read(1'b0);

    // os 7 behaves as 0; stop after 5 reads so the next start is a short read.
    bus.os = 3'd7;
    do_start(0); wait_conv();
    repeat (5) do_read(1'b0);
    bus.os = 3'd0;
    do_start(0); wait_conv(); check_flags();
    repeat (9) do_read(1'b0);

    // Soft reset mid-conversion truncates busy to 50 cycles.
    do_start(0);
    repeat (48) step();
    void'(exp_busy_q.pop_back());
    exp_busy_q.push_back(50);
    do_phy();
    do_read(1'b0); do_read(1'b0); do_read(1'b1);
    do_start(0); wait_conv();
    do_read(1'b0); do_read(1'b1); do_read(1'b0);

    // Start coincident with a read strobe.
    do_start(1); wait_conv(); check_flags();
    repeat (3) do_read(1'b0);

    for (int it = 0; it < 6; it++) begin
      bus.os = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) bus.os = 3'd7;
      bus.range = 1'($urandom_range(0, 1));
      do_start(0);
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(5, 150)) step();
        do_start(0);
      end
      wait_conv(); check_flags();
      n = $urandom_range(0, 11);
      for (int j = 0; j < n; j++) do_read($urandom_range(0, 3) == 0);
      check_flags();
    end

    repeat (5) step();
    check("reads_drained", 32'(exp_q.size()), 32'd0);
    check("busy_drained", 32'(exp_busy_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
